// File: rtl/adc_stats_pkg.sv
// Shared constants for the ADC level statistics engine.
//   ADC_STATS_WIN_LEN / ADC_STATS_OVFL_THR / ADC_STATS_THR0 : register addresses
//   adc_stats_mode_bit() : position of the THR_i mode bit for a given sample width
package adc_stats_pkg;

   localparam logic [3:0] ADC_STATS_WIN_LEN  = 4'd0;
   localparam logic [3:0] ADC_STATS_OVFL_THR = 4'd1;
   localparam logic [3:0] ADC_STATS_THR0     = 4'd2;

   function automatic int adc_stats_mode_bit(input int adc_bits);
      return adc_bits - 1;
   endfunction

endpackage

// File: rtl/adc_thresh_ctr.sv
// One saturating threshold counter with snapshot register.
//   adc_clk, reset : clock, synchronous active-high reset
//   mag, ovfl      : stage-1 sample magnitude and overflow flag
//   thr_cfg        : {mode, level}; mode 0 counts mag >= level, mode 1 counts ovfl
//   clr            : clears the live counter (wins over a counting sample)
//   snap           : copies the live counter (pre-clear value) into snap_cnt
//   snap_cnt       : last captured count
module adc_thresh_ctr
   import adc_stats_pkg::*;
#(
   parameter int ADC_BITS = 14,
   parameter int CNT_BITS = 32
) (
   input  logic                adc_clk,
   input  logic                reset,
   input  logic [ADC_BITS-2:0] mag,
   input  logic                ovfl,
   input  logic [ADC_BITS-1:0] thr_cfg,
   input  logic                clr,
   input  logic                snap,
   output logic [CNT_BITS-1:0] snap_cnt
);

   localparam int MODE_BIT = adc_stats_mode_bit(ADC_BITS);

   logic                hit;
   logic [CNT_BITS-1:0] cnt_d, cnt_q;
   logic [CNT_BITS-1:0] snap_d, snap_q;

   always_comb begin
      hit = thr_cfg[MODE_BIT] ? ovfl : (mag >= thr_cfg[MODE_BIT-1:0]);
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (hit && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
      snap_d = snap ? cnt_q : snap_q;
   end

   always_ff @(posedge adc_clk) begin
      if (reset) begin
         cnt_q  <= '0;
         snap_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         snap_q <= snap_d;
      end
   end

   assign snap_cnt = snap_q;

endmodule

// File: rtl/adc_level_stats.sv
// ADC statistics engine: programmable overflow window with alarm, per-window
// peak magnitude and N saturating threshold counters with atomic snapshot.
//   adc_clk, reset       : clock, synchronous active-high reset
//   adc_data, adc_ovfl   : signed sample and overflow flag, every cycle
//   cfg_we/addr/data     : register write port (WIN_LEN, OVFL_THR, THR_i)
//   snap_req             : snapshot request; snap_valid pulses one cycle later
//   snap_cnt             : captured counters, counter i at [i*CNT_BITS +: CNT_BITS]
//   peak_last            : peak magnitude of the last completed window
//   win_done, ovfl_alarm : window-end pulse and overflow alarm pulse
module adc_level_stats
   import adc_stats_pkg::*;
#(
   parameter int ADC_BITS = 14,
   parameter int WIN_BITS = 16,
   parameter int N_THRESH = 2,
   parameter int CNT_BITS = 32
) (
   input  logic                         adc_clk,
   input  logic                         reset,
   input  logic [ADC_BITS-1:0]          adc_data,
   input  logic                         adc_ovfl,
   input  logic                         cfg_we,
   input  logic [3:0]                   cfg_addr,
   input  logic [31:0]                  cfg_data,
   input  logic                         snap_req,
   output logic                         snap_valid,
   output logic [N_THRESH*CNT_BITS-1:0] snap_cnt,
   output logic [ADC_BITS-2:0]          peak_last,
   output logic                         ovfl_alarm,
   output logic                         win_done
);

   localparam int MAG_BITS = ADC_BITS - 1;

   logic [MAG_BITS-1:0] mag_d, mag_q;
   logic                ovfl_q;

   logic                win_len_we, ovfl_thr_we;
   logic [N_THRESH-1:0] thr_we;
   logic [WIN_BITS-1:0] win_len_d, win_len_q;
   logic [31:0]         ovfl_thr_d, ovfl_thr_q;
   logic [ADC_BITS-1:0] thr_d [N_THRESH];
   logic [ADC_BITS-1:0] thr_q [N_THRESH];

   logic [WIN_BITS-1:0] win_cnt_d, win_cnt_q;
   logic [WIN_BITS-1:0] ovfl_cnt_d, ovfl_cnt_q, ovfl_incl;
   logic [MAG_BITS-1:0] peak_d, peak_q, peak_incl;
   logic [MAG_BITS-1:0] peak_last_d, peak_last_q;
   logic                win_done_d, win_done_q;
   logic                alarm_d, alarm_q;
   logic                snap_valid_d, snap_valid_q;

   // Most negative code has no positive twin; clamp it to full scale.
   always_comb begin
      if (!adc_data[ADC_BITS-1]) begin
         mag_d = adc_data[MAG_BITS-1:0];
      end else if (adc_data[MAG_BITS-1:0] == '0) begin
         mag_d = '1;
      end else begin
         mag_d = ~adc_data[MAG_BITS-1:0] + 1'b1;
      end
   end

   always_comb begin
      win_len_we  = cfg_we && (cfg_addr == ADC_STATS_WIN_LEN);
      ovfl_thr_we = cfg_we && (cfg_addr == ADC_STATS_OVFL_THR);
      for (int i = 0; i < N_THRESH; i++) begin
         thr_we[i] = cfg_we && (cfg_addr == ADC_STATS_THR0 + 4'(i));
         thr_d[i]  = thr_we[i] ? cfg_data[ADC_BITS-1:0] : thr_q[i];
      end
      win_len_d  = win_len_we  ? cfg_data[WIN_BITS-1:0] : win_len_q;
      ovfl_thr_d = ovfl_thr_we ? cfg_data : ovfl_thr_q;
   end

   // Window timer counts down from WIN_LEN; terminal count 0 is the last
   // sample of the window.
   always_comb begin
      ovfl_incl   = (ovfl_q && (ovfl_cnt_q != '1)) ? ovfl_cnt_q + 1'b1 : ovfl_cnt_q;
      peak_incl   = (mag_q > peak_q) ? mag_q : peak_q;
      win_cnt_d   = win_cnt_q - 1'b1;
      ovfl_cnt_d  = ovfl_incl;
      peak_d      = peak_incl;
      peak_last_d = peak_last_q;
      win_done_d  = 1'b0;
      alarm_d     = 1'b0;
      if (win_len_we) begin
         win_cnt_d  = cfg_data[WIN_BITS-1:0];
         ovfl_cnt_d = '0;
         peak_d     = '0;
      end else if (win_cnt_q == '0) begin
         win_done_d  = 1'b1;
         alarm_d     = 32'(ovfl_incl) >= ovfl_thr_q;
         peak_last_d = peak_incl;
         win_cnt_d   = win_len_q;
         ovfl_cnt_d  = '0;
         peak_d      = '0;
      end
      snap_valid_d = snap_req;
   end

   always_ff @(posedge adc_clk) begin
      if (reset) begin
         mag_q        <= '0;
         ovfl_q       <= 1'b0;
         win_len_q    <= '1;
         ovfl_thr_q   <= 32'd1;
         for (int i = 0; i < N_THRESH; i++) begin
            thr_q[i] <= '0;
         end
         // Timer is preloaded with the reset WIN_LEN so the first window
         // after reset is full length.
         win_cnt_q    <= '1;
         ovfl_cnt_q   <= '0;
         peak_q       <= '0;
         peak_last_q  <= '0;
         win_done_q   <= 1'b0;
         alarm_q      <= 1'b0;
         snap_valid_q <= 1'b0;
      end else begin
         mag_q        <= mag_d;
         ovfl_q       <= adc_ovfl;
         win_len_q    <= win_len_d;
         ovfl_thr_q   <= ovfl_thr_d;
         for (int i = 0; i < N_THRESH; i++) begin
            thr_q[i] <= thr_d[i];
         end
         win_cnt_q    <= win_cnt_d;
         ovfl_cnt_q   <= ovfl_cnt_d;
         peak_q       <= peak_d;
         peak_last_q  <= peak_last_d;
         win_done_q   <= win_done_d;
         alarm_q      <= alarm_d;
         snap_valid_q <= snap_valid_d;
      end
   end

   for (genvar g = 0; g < N_THRESH; g++) begin : g_ctr
      adc_thresh_ctr #(
         .ADC_BITS (ADC_BITS),
         .CNT_BITS (CNT_BITS)
      ) u_ctr (
         .adc_clk  (adc_clk),
         .reset    (reset),
         .mag      (mag_q),
         .ovfl     (ovfl_q),
         .thr_cfg  (thr_q[g]),
         .clr      (thr_we[g]),
         .snap     (snap_req),
         .snap_cnt (snap_cnt[g*CNT_BITS +: CNT_BITS])
      );
   end

   assign snap_valid = snap_valid_q;
   assign peak_last  = peak_last_q;
   assign ovfl_alarm = alarm_q;
   assign win_done   = win_done_q;

endmodule

// File: tb/tb_adc_level_stats.sv
module tb_adc_level_stats;

   localparam int AB  = 14;
   localparam int NT  = 2;
   localparam int CB  = 32;
   localparam int CBS = 4;
   localparam int MAGMAX = 8191;
   localparam longint CMAX  = 64'd4294967295;
   localparam longint CMAXS = 64'd15;
   localparam longint OMAX  = 64'd65535;

   logic          adc_clk  = 1'b0;
   logic          reset    = 1'b1;
   logic [AB-1:0] adc_data = '0;
   logic          adc_ovfl = 1'b0;
   logic          cfg_we   = 1'b0;
   logic [3:0]    cfg_addr = '0;
   logic [31:0]   cfg_data = '0;
   logic          snap_req = 1'b0;

   logic              snap_valid, ovfl_alarm, win_done;
   logic [NT*CB-1:0]  snap_cnt;
   logic [AB-2:0]     peak_last;
   logic              s_snap_valid, s_ovfl_alarm, s_win_done;
   logic [NT*CBS-1:0] s_snap_cnt;
   logic [AB-2:0]     s_peak_last;

   adc_level_stats #(.ADC_BITS(AB), .WIN_BITS(16), .N_THRESH(NT), .CNT_BITS(CB)) dut (
      .adc_clk(adc_clk), .reset(reset), .adc_data(adc_data), .adc_ovfl(adc_ovfl),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .snap_req(snap_req),
      .snap_valid(snap_valid), .snap_cnt(snap_cnt), .peak_last(peak_last),
      .ovfl_alarm(ovfl_alarm), .win_done(win_done));

   adc_level_stats #(.ADC_BITS(AB), .WIN_BITS(16), .N_THRESH(NT), .CNT_BITS(CBS)) dut_small (
      .adc_clk(adc_clk), .reset(reset), .adc_data(adc_data), .adc_ovfl(adc_ovfl),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .snap_req(snap_req),
      .snap_valid(s_snap_valid), .snap_cnt(s_snap_cnt), .peak_last(s_peak_last),
      .ovfl_alarm(s_ovfl_alarm), .win_done(s_win_done));

   always #5 adc_clk = ~adc_clk;

   int errors = 0;
   int checks = 0;
   int n_done = 0;
   int n_alarm = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   longint m_win_len, m_ovfl_thr;
   int     m_thr [NT];
   longint m_cnt [NT], m_cnt_s [NT], m_snap [NT], m_snap_s [NT];
   longint m_pos, m_ocnt, oi;
   int     m_peak, pk, p_mag, lvl;
   bit     p_ovfl, hit, mode;
   bit     e_done, e_alarm, e_sv;
   int     e_peak_last;
   bit     started = 1'b0;

   function automatic int mag_of(input logic [AB-1:0] d);
      int v;
      v = int'($signed(d));
      if (v < 0) v = -v;
      if (v > MAGMAX) v = MAGMAX;
      return v;
   endfunction

   function automatic bit wr_to(input int a);
      return cfg_we && (int'(cfg_addr) == a);
   endfunction

   always @(posedge adc_clk) begin
      if (reset) begin
         m_win_len = OMAX;
         m_ovfl_thr = 1;
         for (int i = 0; i < NT; i++) begin
            m_thr[i] = 0; m_cnt[i] = 0; m_cnt_s[i] = 0; m_snap[i] = 0; m_snap_s[i] = 0;
         end
         m_pos = 0; m_ocnt = 0; m_peak = 0; p_mag = 0; p_ovfl = 0;
         e_done = 0; e_alarm = 0; e_sv = 0; e_peak_last = 0;
      end else begin
         // sample being counted now is the one captured at the previous edge
         for (int i = 0; i < NT; i++) begin
            mode = m_thr[i][13];
            lvl  = m_thr[i] & 8191;
            hit  = mode ? p_ovfl : (p_mag >= lvl);
            if (snap_req) begin
               m_snap[i] = m_cnt[i];
               m_snap_s[i] = m_cnt_s[i];
            end
            if (wr_to(2 + i)) begin
               m_cnt[i] = 0; m_cnt_s[i] = 0;
            end else if (hit) begin
               if (m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
               if (m_cnt_s[i] < CMAXS) m_cnt_s[i] = m_cnt_s[i] + 1;
            end
         end
         e_sv = snap_req;
         if (wr_to(0)) begin
            m_win_len = longint'(cfg_data[15:0]);
            m_pos = 0; m_ocnt = 0; m_peak = 0; e_done = 0; e_alarm = 0;
         end else begin
            oi = m_ocnt + longint'(p_ovfl);
            if (oi > OMAX) oi = OMAX;
            pk = (p_mag > m_peak) ? p_mag : m_peak;
            if (m_pos == m_win_len) begin
               e_done = 1; e_alarm = (oi >= m_ovfl_thr); e_peak_last = pk;
               m_pos = 0; m_ocnt = 0; m_peak = 0;
            end else begin
               e_done = 0; e_alarm = 0;
               m_pos = m_pos + 1; m_ocnt = oi; m_peak = pk;
            end
         end
         if (wr_to(1)) m_ovfl_thr = longint'(cfg_data);
         for (int i = 0; i < NT; i++) if (wr_to(2 + i)) m_thr[i] = int'(cfg_data[13:0]);
         p_mag  = mag_of(adc_data);
         p_ovfl = adc_ovfl;
      end
      started = 1'b1;
   end

   // ---------------- per-cycle compare ----------------
   logic [63:0] ev;
   logic [7:0]  evs;

   always @(negedge adc_clk) begin
      if (started) begin
         ev = '0; evs = '0;
         for (int i = 0; i < NT; i++) begin
            ev[i*CB +: CB]   = m_snap[i][31:0];
            evs[i*CBS +: CBS] = m_snap_s[i][3:0];
         end
         check("win_done",   64'(win_done),    64'(e_done));
         check("ovfl_alarm", 64'(ovfl_alarm),  64'(e_alarm));
         check("peak_last",  64'(peak_last),   64'(e_peak_last));
         check("snap_valid", 64'(snap_valid),  64'(e_sv));
         check("snap_cnt",   64'(snap_cnt),    ev);
         check("s_snap_cnt", 64'(s_snap_cnt),  64'(evs));
         check("s_win_done", 64'(s_win_done),  64'(e_done));
         if (win_done === 1'b1) n_done++;
         if (ovfl_alarm === 1'b1) n_alarm++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic nxt();
      @(negedge adc_clk);
      cfg_we = 1'b0;
      snap_req = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      nxt();
   endtask

   task automatic snap();
      snap_req = 1'b1;
      nxt();
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) @(negedge adc_clk);
      check("rst_win_done",   64'(win_done),   64'd0);
      check("rst_alarm",      64'(ovfl_alarm), 64'd0);
      check("rst_peak_last",  64'(peak_last),  64'd0);
      check("rst_snap_cnt",   64'(snap_cnt),   64'd0);

      // constant 100 sample, THR_0 = level 100 mode 0 written in cycle 1
      reset = 1'b0;
      adc_data = 14'd100;
      nxt();
      wr(4'd2, 32'd100);
      repeat (8) nxt();
      snap();
      check("t1_snap0", 64'(snap_cnt[31:0]), 64'd8);
      check("t1_snap_valid", 64'(snap_valid), 64'd1);

      // windows of 16 samples, alarm threshold 3
      wr(4'd1, 32'd3);
      wr(4'd0, 32'd15);
      n_done = 0; n_alarm = 0;
      for (int k = 1; k <= 70; k++) begin
         adc_ovfl = ((k >= 1) && (k <= 3)) || (k == 20) || (k == 21);
         if (k >= 48)      adc_data = (k == 55) ? 14'(-50) : 14'd50;
         else if (k >= 32) adc_data = (k == 40) ? 14'h2000 : 14'd100;
         else              adc_data = 14'd100;
         nxt();
         if (k == 19) begin
            check("t2_done_3ovfl",  64'(n_done),  64'd1);
            check("t2_alarm_3ovfl", 64'(n_alarm), 64'd1);
            n_done = 0; n_alarm = 0;
         end
         if (k == 35) begin
            check("t2_done_2ovfl",  64'(n_done),  64'd1);
            check("t2_alarm_2ovfl", 64'(n_alarm), 64'd0);
         end
         if (k == 51) check("t3_peak_min", 64'(peak_last), 64'd8191);
         if (k == 67) check("t3_peak_50",  64'(peak_last), 64'd50);
      end
      adc_ovfl = 1'b0;

      // WIN_LEN=7 written on the window-end cycle of WIN_LEN=3
      wr(4'd0, 32'd3);
      n_done = 0;
      repeat (3) nxt();
      wr(4'd0, 32'd7);
      nxt();
      check("t5_no_done", 64'(n_done), 64'd0);
      repeat (9) nxt();
      check("t5_next_done", 64'(n_done), 64'd1);

      // counter 1 reaches 42, then THR_1 write together with snapshot
      wr(4'd3, 32'd0);
      repeat (42) nxt();
      cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 32'h1FFF;
      snap();
      check("t6_snap1_42",   64'(snap_cnt[63:32]), 64'd42);
      check("t4_small_sat",  64'(s_snap_cnt[7:4]), 64'd15);
      repeat (3) nxt();
      snap();
      check("t6_live1_zero", 64'(snap_cnt[63:32]), 64'd0);

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) begin
            reset = 1'b1;
            repeat (2) nxt();
            reset = 1'b0;
         end
         case ($urandom_range(0, 3))
            0: adc_data = 14'($urandom);
            1: adc_data = 14'h2000;
            2: adc_data = 14'($signed($urandom_range(0, 600)) - 300);
            default: ;
         endcase
         adc_ovfl = ($urandom_range(0, 3) == 0);
         snap_req = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 11) == 0) begin
            cfg_we = 1'b1;
            cfg_addr = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(4, 15))
                                                   : 4'($urandom_range(0, 3));
            case (cfg_addr)
               4'd0: cfg_data = $urandom_range(0, 20);
               4'd1: cfg_data = $urandom_range(0, 4);
               4'd2, 4'd3: cfg_data = {18'd0, 1'($urandom_range(0, 1)),
                                       ($urandom_range(0, 1) == 1) ? 13'($urandom) : 13'($urandom_range(0, 300))};
               default: cfg_data = $urandom;
            endcase
         end
         nxt();
      end

      repeat (2) nxt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/adc_level_stats.md
# adc_level_stats

Parametrised ADC statistics engine in the `adc_clk` domain, feeding the receiver's overflow alarm and level counters. It generalises the fixed 64k-sample overflow window and single level counter in three ways:
- programmable window length and overflow threshold;
- per-window peak-magnitude capture;
- N independent saturating threshold counters with atomic snapshot.

Configuration arrives as write strobes already synchronised into `adc_clk`; snapshots are read back by the cpu-side sync logic.

## Interface
Parameters:
- `ADC_BITS`, 14, ADC sample width (signed).
- `WIN_BITS`, 16, window length counter width.
- `N_THRESH`, 2, number of threshold counters (1..8).
- `CNT_BITS`, 32, threshold counter width.

Ports:
- `adc_clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `adc_data`  in  ADC_BITS  signed sample, valid every cycle.
- `adc_ovfl`  in  1  ADC overflow flag for the same sample.
- `cfg_we`  in  1  config write strobe, one cycle.
- `cfg_addr`  in  4  register select.
- `cfg_data`  in  32  write data.
- `snap_req`  in  1  snapshot request pulse.
- `snap_valid`  out  1  one-cycle pulse; snapshot outputs updated.
- `snap_cnt`  out  N_THRESH*CNT_BITS  threshold counts; counter i at `[i*CNT_BITS +: CNT_BITS]`.
- `peak_last`  out  ADC_BITS-1  peak magnitude of the last completed window.
- `ovfl_alarm`  out  1  one-cycle pulse at window end when the overflow count is at or above the threshold.
- `win_done`  out  1  one-cycle pulse at every window end.

## Operation
Magnitude:
- `mag = |adc_data|`, saturating: -2^(ADC_BITS-1) maps to 2^(ADC_BITS-1)-1. Width ADC_BITS-1.

Registers (reset value in parentheses):
- addr 0 `WIN_LEN` (2^WIN_BITS-1). A window spans WIN_LEN+1 samples. Writing it restarts the window: window counter, overflow count and running peak all clear, with no `win_done` pulse.
- addr 1 `OVFL_THR` (1). A value of 0 raises the alarm at every window end.
- addr 2+i `THR_i`, for i < N_THRESH (0):
  - bit ADC_BITS-1 is the mode bit. 0 = count samples with `mag >= level`; 1 = count samples with `adc_ovfl` set.
  - bits ADC_BITS-2:0 are `level`.
  - Writing THR_i clears counter i.
- Writes to addr ≥ 2+N_THRESH are ignored.

Window:
- The window counter increments on every stage-1 sample.
- The overflow count accumulates `adc_ovfl` and saturates at 2^WIN_BITS-1.
- The running peak is the maximum of `mag`.
- At the cycle where the counter equals WIN_LEN:
  - `win_done` = 1;
  - `ovfl_alarm = (ovfl_count_incl_current >= OVFL_THR)`;
  - `peak_last` ← peak including the current sample;
  - counter, overflow count and running peak all clear.

Threshold counters:
- Free-running; saturate at 2^CNT_BITS-1 and never wrap.
- Not cleared at window end.

Snapshot:
- `snap_req` copies all N counters into `snap_cnt` in the same edge; `snap_valid` pulses the next cycle.
- Counters keep running and are not cleared.

Simultaneous events:
- `cfg_we` to THR_i together with a counting sample: the clear wins, so the counter becomes 0.
- `snap_req` together with a THR_i write: the snapshot captures the pre-clear value.
- `cfg_we` to WIN_LEN at the window-end cycle: the restart wins, with no `win_done` and no alarm.

Reset: every output and internal register goes to 0, except the configuration registers, which take their reset values above.

## Timing
- Stage 1 registers `mag` and `adc_ovfl`.
- Stage 2 updates the counters and window logic.
- Sample presented at cycle t:
  - affects its counter at edge t+2;
  - at window end, `win_done`/`ovfl_alarm` are high during cycle t+2.
- `snap_req` at cycle t: `snap_cnt` is valid from t+1, and `snap_valid` is high during t+1.
- Back-to-back `snap_req` is legal: one snapshot and one `snap_valid` per request.
- Config writes take effect at the next edge. The two pipeline samples already in flight are counted under the new settings.
- After reset deassertion the pipeline holds zeros for two cycles: `mag` = 0, which counts for a threshold with level 0.

## Structure
- Package `adc_stats_pkg`:
  - address constants `ADC_STATS_WIN_LEN`, `ADC_STATS_OVFL_THR`, `ADC_STATS_THR0`;
  - mode-bit position function of ADC_BITS.
- Sub-module `adc_thresh_ctr`, instanced N_THRESH times. It takes the stage-1 `mag`/`ovfl`, its configuration, clear and snapshot inputs, and produces its own counter and snapshot.
- The top holds magnitude, window and peak logic and the register decode.

## Test plan
- Reset, then a constant sample of 100 with THR_0 level 100, mode 0. Expect counter 0 to increment every cycle; a `snap_req` at cycle 10 after reset returns 8.
- WIN_LEN = 15, OVFL_THR = 3, `adc_ovfl` high on 3 samples of a window. Expect `ovfl_alarm` once at the 16th sample plus 2 cycles. With only 2 overflow samples, expect no alarm but `win_done` still pulses.
- Sample -8192 with ADC_BITS = 14. Expect `mag` = 8191 and `peak_last` = 8191 at the window end; the following window's peak of 50 replaces it.
- CNT_BITS = 4, THR_0 level 0, run 20 cycles. Expect the counter to stick at 15.
- Write WIN_LEN = 7 at the window-end cycle of WIN_LEN = 3. Expect no `win_done` that cycle and the next `win_done` 8 samples later.
- THR_1 write concurrent with `snap_req`, counter 1 at 42. Expect `snap_cnt[1]` = 42 and the live counter = 0.
